// File: rtl/uart_apb_fifo.sv
// 8N1 UART behind a single-cycle-response APB-style slave port.
// TX path: write FIFO drained by a baud serializer; RX path: 2-flop sync, oversampled deserializer, one-deep RBR.
module uart_apb_fifo #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          TX_DEPTH    = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  ready,
    output logic                  perr,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  irq
);
    // state     | meaning
    // TX_IDLE   | line high, waiting for FIFO data
    // TX_START  | driving start bit (low)
    // TX_DATA   | driving 8 data bits, LSB first
    // TX_STOP   | driving stop bit (high); may chain straight into TX_START
    // RX_IDLE   | waiting for a high->low transition on the synchronised line
    // RX_START  | waiting half a bit to confirm the start bit
    // RX_DATA   | sampling 8 data bits, one per bit period
    // RX_STOP   | sampling the stop bit, then delivering the byte
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_W = ADDR_WIDTH'(BASE_ADDR);

    logic                  access;
    logic                  in_block;
    logic [3:0]            offset;
    logic [1:0]            lane;
    logic [7:0]            wr_byte;
    logic                  lane_stb;
    logic                  sel_thr, sel_ier, sel_lsr, sel_div;
    logic                  thr_push_req, thr_push, thr_drop;
    logic                  lsr_wr, rbr_rd, lsr_rd;
    logic [15:0]           rd_raw;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [15:0]           div_new;

    logic [1:0]  ier;
    logic [15:0] div;
    logic [7:0]  rbr;
    logic        dr, oe, fe;
    logic        thre, temt;
    logic [7:0]  lsr;

    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_head;

    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [7:0]  tx_shreg;
    logic [2:0]  tx_bitn;
    logic        tx_bit_done;
    logic        tx_pop;

    logic        rx_meta, rx_sync, rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_shreg;
    logic [2:0]  rx_bitn;
    logic        rx_tick;
    logic        rx_deliver;
    logic        rx_frame_err;

    logic        unused_bits;

    assign unused_bits = ^{pdata[DATA_WIDTH-1:16]};

    // Bus decode
    assign access   = psel & penable & ~ready;
    assign in_block = (paddr[ADDR_WIDTH-1:4] == BASE_W[ADDR_WIDTH-1:4]);
    assign offset   = paddr[3:0];
    assign lane     = paddr[1:0];
    assign wr_byte  = pdata[{lane, 3'b000} +: 8];
    assign lane_stb = pstb[lane];

    assign sel_thr = access & in_block & (offset == 4'd0);
    assign sel_ier = access & in_block & (offset == 4'd1);
    assign sel_lsr = access & in_block & (offset == 4'd5);
    assign sel_div = access & in_block & (offset == 4'd8);

    // A pop on the same edge frees a slot, so a write into a full FIFO is still accepted.
    assign thr_push_req = sel_thr & pwrite & lane_stb;
    assign thr_push     = thr_push_req & (~fifo_full | tx_pop);
    assign thr_drop     = thr_push_req & ~thr_push;
    assign lsr_wr       = sel_lsr & pwrite;
    assign rbr_rd       = sel_thr & ~pwrite;
    assign lsr_rd       = sel_lsr & ~pwrite;

    assign thre = fifo_empty;
    assign temt = fifo_empty & (tx_state == TX_IDLE);
    assign lsr  = {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};
    assign irq  = (dr & ier[0]) | (thre & ier[1]);

    always_comb begin
        rd_raw = 16'd0;
        if (in_block) begin
            case (offset)
                4'd0:    rd_raw = {8'd0, rbr};
                4'd1:    rd_raw = {14'd0, ier};
                4'd5:    rd_raw = {8'd0, lsr};
                4'd8:    rd_raw = div;
                default: rd_raw = 16'd0;
            endcase
        end
        rd_word = DATA_WIDTH'(rd_raw) << {lane, 3'b000};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ready  <= 1'b0;
            perr   <= 1'b0;
            prdata <= '0;
        end else begin
            ready  <= access;
            perr   <= access & (thr_drop | lsr_wr);
            prdata <= (access & ~pwrite) ? rd_word : '0;
        end
    end

    // Configuration registers
    always_comb begin
        div_new[15:8] = pstb[1] ? pdata[15:8] : div[15:8];
        div_new[7:0]  = pstb[0] ? pdata[7:0]  : div[7:0];
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ier <= 2'b00;
            div <= DEFAULT_DIV;
        end else begin
            if (sel_ier & pwrite & lane_stb)
                ier <= wr_byte[1:0];
            if (sel_div & pwrite)
                div <= (div_new == 16'd0) ? 16'd1 : div_new;
        end
    end

    // TX FIFO
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rptr[AW-1:0]];

    always_ff @(posedge pclk) begin
        if (thr_push)
            fifo_mem[wptr[AW-1:0]] <= wr_byte;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (thr_push)
                wptr <= wptr + 1'b1;
            if (tx_pop)
                rptr <= rptr + 1'b1;
        end
    end

    // TX serializer; the bit timer reloads from DIV at every bit boundary.
    assign tx_bit_done = (tx_cnt == 16'd0);
    assign tx_pop      = ~fifo_empty &
                         ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_done));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_shreg <= 8'd0;
            tx_bitn  <= 3'd0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_cnt   <= div - 16'd1;
                        tx_shreg <= fifo_head;
                        txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_done) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= div - 16'd1;
                        tx_bitn  <= 3'd0;
                        txd      <= tx_shreg[0];
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_done) begin
                        tx_cnt <= div - 16'd1;
                        if (tx_bitn == 3'd7) begin
                            tx_state <= TX_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            txd      <= tx_shreg[1];
                            tx_bitn  <= tx_bitn + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_bit_done) begin
                        tx_cnt <= div - 16'd1;
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_shreg <= fifo_head;
                            txd      <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // RX synchroniser; resets high so reset release never looks like a start bit.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_tick      = (rx_cnt <= 16'd1);
    assign rx_deliver   = (rx_state == RX_STOP) & rx_tick;
    assign rx_frame_err = rx_deliver & ~rx_sync;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_shreg <= 8'd0;
            rx_bitn  <= 3'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev & ~rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= {1'b0, div[15:1]};
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= div;
                            rx_bitn  <= 3'd0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shreg <= {rx_sync, rx_shreg[7:1]};
                        rx_cnt   <= div;
                        if (rx_bitn == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bitn <= rx_bitn + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_tick)
                        rx_state <= RX_IDLE;
                    else
                        rx_cnt <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    // Receive buffer and line status; a new error beats a clearing LSR read.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rbr <= 8'd0;
            dr  <= 1'b0;
            oe  <= 1'b0;
            fe  <= 1'b0;
        end else begin
            if (rx_deliver & (~dr | rbr_rd)) begin
                rbr <= rx_shreg;
                dr  <= 1'b1;
            end else if (rbr_rd) begin
                dr <= 1'b0;
            end
            if (rx_deliver & dr & ~rbr_rd)
                oe <= 1'b1;
            else if (lsr_rd)
                oe <= 1'b0;
            if (rx_frame_err)
                fe <= 1'b1;
            else if (lsr_rd)
                fe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed bench for uart_apb_fifo: register vector table plus hand-written TX/RX/FIFO/reset sequences.
module tb_uart_apb_fifo;
    localparam logic [31:0] B = 32'h1000_0000;

    logic        pclk, presetn;
    logic [31:0] paddr, pdata, prdata;
    logic        psel, penable, pwrite;
    logic [3:0]  pstb;
    logic        ready, perr, txd, rxd, irq;

    int checks = 0;
    int failures = 0;

    uart_apb_fifo dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pdata(pdata), .prdata(prdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb), .ready(ready),
        .perr(perr), .txd(txd), .rxd(rxd), .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Free-running cycle count and falling-edge log of txd
    int cyc = 0;
    logic tx_prev = 1'b1;
    int falls[$];
    always @(negedge pclk) begin
        cyc <= cyc + 1;
        tx_prev <= txd;
        if (tx_prev && !txd) falls.push_back(cyc);
    end

    // Serial decoder for txd at a known bit period
    logic       mon_en = 1'b0;
    int         mon_div = 2;
    int         mon_stop_err = 0;
    logic [7:0] mon_byte;
    logic [7:0] mon_q[$];
    always begin
        @(negedge pclk);
        if (mon_en && txd == 1'b0) begin
            repeat (mon_div / 2) @(negedge pclk);
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(negedge pclk);
                mon_byte[i] = txd;
            end
            repeat (mon_div) @(negedge pclk);
            if (txd !== 1'b1) mon_stop_err = mon_stop_err + 1;
            mon_q.push_back(mon_byte);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] stb, output logic [31:0] rd, output logic err);
        logic ok;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = data; pstb = stb;
        @(negedge pclk);
        penable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge pclk);
            if (ready) ok = 1'b1;
        end
        rd = prdata; err = perr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL apb_timeout addr=0x%0h actual=no_ready expected=ready", addr);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, addr, 32'h0, 4'h0, rd, err);
        check(nm, rd, exp);
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] stb, output logic err);
        logic [31:0] rd;
        apb(1'b1, addr, data, stb, rd, err);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        rxd = 1'b0;
        repeat (div) @(negedge pclk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (div) @(negedge pclk);
        end
        rxd = stop;
        repeat (div) @(negedge pclk);
        rxd = 1'b1;
        repeat (div) @(negedge pclk);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  stb;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t        vecs[18];
    logic [7:0]  wrap_bytes[10];
    logic [7:0]  b55;
    logic [31:0] rd;
    logic        err;
    int          err_cnt;
    int          bad;
    logic        exp_bit;

    initial begin
        vecs[0]  = '{1'b0, B + 32'h5, 32'h0,          4'h0, 32'h0000_6000, 1'b0};
        vecs[1]  = '{1'b0, B + 32'h1, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, B + 32'h8, 32'h0,          4'h0, 32'h0000_0364, 1'b0};
        vecs[3]  = '{1'b1, B + 32'h1, 32'h0000_0300,  4'h2, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, B + 32'h1, 32'h0,          4'h0, 32'h0000_0300, 1'b0};
        vecs[5]  = '{1'b1, B + 32'h1, 32'h0000_0000,  4'h2, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, B + 32'h1, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, B + 32'h8, 32'h0000_0000,  4'h3, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, B + 32'h8, 32'h0,          4'h0, 32'h0000_0001, 1'b0};
        vecs[9]  = '{1'b1, B + 32'h8, 32'hABCD_0004,  4'h1, 32'h0,         1'b0};
        vecs[10] = '{1'b0, B + 32'h8, 32'h0,          4'h0, 32'h0000_0004, 1'b0};
        vecs[11] = '{1'b1, B + 32'h5, 32'hFFFF_FFFF,  4'hF, 32'h0,         1'b1};
        vecs[12] = '{1'b0, B + 32'h5, 32'h0,          4'h0, 32'h0000_6000, 1'b0};
        vecs[13] = '{1'b0, B + 32'h3, 32'h0,          4'h0, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, B + 32'hC, 32'hFFFF_FFFF,  4'hF, 32'h0,         1'b0};
        vecs[15] = '{1'b1, B + 32'h0, 32'h0000_0077,  4'h0, 32'h0,         1'b0};
        vecs[16] = '{1'b0, B + 32'h5, 32'h0,          4'h0, 32'h0000_6000, 1'b0};
        vecs[17] = '{1'b0, 32'h2000_0000, 32'h0,      4'h0, 32'h0000_0000, 1'b0};
        wrap_bytes = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h00, 8'hFF, 8'h96, 8'h69, 8'hA5, 8'h5A};

        presetn = 1'b0; rxd = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pdata = '0; pstb = '0;
        repeat (3) @(negedge pclk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_perr", {31'd0, perr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);

        // Register map vectors (leaves DIV=4)
        for (int i = 0; i < 18; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].stb, rd, err);
            check($sformatf("vec%0d_perr", i), {31'd0, err}, {31'd0, vecs[i].err});
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
        end
        @(negedge pclk);
        check("ready_one_cycle", {31'd0, ready}, 32'd0);
        check("prdata_idle_zero", prdata, 32'd0);

        // 0x55 at DIV=4: every bit exactly 4 clocks
        b55 = 8'h55;
        wr_reg(B, 32'h55, 4'h1, err);
        for (int i = 0; i < 20 && txd; i++) @(negedge pclk);
        check("tx55_start_seen", {31'd0, txd}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b55[k-1];
            bad = 0;
            for (int j = 0; j < 4; j++) begin
                if (k > 0 || j > 0) @(negedge pclk);
                if (txd !== exp_bit) bad++;
            end
            check($sformatf("tx55_bit%0d", k), {31'd0, txd}, {31'd0, exp_bit});
            if (bad != 0) check($sformatf("tx55_bit%0d_width", k), bad, 0);
        end
        repeat (4) @(negedge pclk);
        rd_chk("tx55_lsr_after", B + 32'h5, 32'h0000_6000);

        // FIFO wrap-around at DIV=2, decoded from txd
        wr_reg(B + 32'h8, 32'h2, 4'h3, err);
        mon_div = 2; mon_q.delete(); mon_stop_err = 0; mon_en = 1'b1;
        err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            wr_reg(B, {24'd0, wrap_bytes[i]}, 4'h1, err);
            if (err) err_cnt++;
        end
        check("wrap_perr_count", err_cnt, 0);
        for (int i = 0; i < 2000 && mon_q.size() < 10; i++) @(negedge pclk);
        mon_en = 1'b0;
        check("wrap_frame_count", mon_q.size(), 10);
        for (int i = 0; i < 10 && i < mon_q.size(); i++)
            check($sformatf("wrap_byte%0d", i), {24'd0, mon_q[i]}, {24'd0, wrap_bytes[i]});
        check("wrap_stop_bits", mon_stop_err, 0);

        // RX at DIV=8
        wr_reg(B + 32'h8, 32'h8, 4'h3, err);
        wr_reg(B + 32'h1, 32'h0100, 4'h2, err);
        check("rx_irq_before", {31'd0, irq}, 32'd0);
        send_rx(8'hA3, 1'b1, 8);
        check("rx_irq_dr", {31'd0, irq}, 32'd1);
        rd_chk("rx_lsr_dr", B + 32'h5, 32'h0000_6100);
        rd_chk("rx_rbr_a3", B, 32'h0000_00A3);
        check("rx_irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("rx_lsr_clear", B + 32'h5, 32'h0000_6000);

        send_rx(8'h11, 1'b1, 8);
        send_rx(8'h22, 1'b1, 8);
        rd_chk("ovr_lsr_63", B + 32'h5, 32'h0000_6300);
        rd_chk("ovr_rbr_first", B, 32'h0000_0011);
        rd_chk("ovr_lsr_60", B + 32'h5, 32'h0000_6000);

        send_rx(8'h5A, 1'b0, 8);
        rd_chk("fe_lsr_69", B + 32'h5, 32'h0000_6900);
        rd_chk("fe_rbr", B, 32'h0000_005A);
        rd_chk("fe_lsr_cleared", B + 32'h5, 32'h0000_6000);

        @(negedge pclk); rxd = 1'b0;
        @(negedge pclk); rxd = 1'b1;
        repeat (120) @(negedge pclk);
        rd_chk("glitch_lsr", B + 32'h5, 32'h0000_6000);

        // FIFO full at DIV=1000, back-to-back frames, then reset mid-frame
        wr_reg(B + 32'h8, 32'h03E8, 4'h3, err);
        wr_reg(B + 32'h1, 32'h0200, 4'h2, err);
        check("irq_thre", {31'd0, irq}, 32'd1);
        falls.delete();
        err_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            wr_reg(B, 32'hFF, 4'h1, err);
            if (err) err_cnt++;
        end
        check("full_accepted_perr", err_cnt, 0);
        wr_reg(B, 32'hFF, 4'h1, err);
        check("full_drop_perr", {31'd0, err}, 32'd1);
        check("full_irq_low", {31'd0, irq}, 32'd0);
        rd_chk("full_lsr", B + 32'h5, 32'h0000_0000);
        for (int i = 0; i < 12000 && falls.size() < 2; i++) @(negedge pclk);
        check("b2b_fall_count", falls.size(), 2);
        if (falls.size() >= 2) check("b2b_frame_gap", falls[1] - falls[0], 10000);

        repeat (100) @(negedge pclk);
        check("mid_frame_txd_low", {31'd0, txd}, 32'd0);
        presetn = 1'b0;
        #1;
        check("async_reset_txd", {31'd0, txd}, 32'd1);
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        rd_chk("post_rst_lsr", B + 32'h5, 32'h0000_6000);
        rd_chk("post_rst_div", B + 32'h8, 32'h0000_0364);
        rd_chk("post_rst_ier", B + 32'h1, 32'h0000_0000);
        rd_chk("post_rst_rbr", B, 32'h0000_0000);
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        repeat (50) @(negedge pclk);
        check("post_rst_txd_idle", {31'd0, txd}, 32'd1);
        check("post_rst_no_frames", falls.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_apb_fifo.md
Name: uart_apb_fifo

Overview:
- Parametrised successor to the simulation-only console UART: a real 8N1 serial transmitter and receiver behind the same APB-style slave port.
- Writes to THR enter a TX FIFO that a baud-rate serializer drains onto txd.
- rxd is synchronised, oversampled by the bit-period counter, and delivered through a one-deep receive buffer.
- 16550-compatible offsets (THR/RBR at +0, LSR at +5) so existing firmware polling LSR keeps working; sits at BASE_ADDR on the peripheral bus.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width; byte lanes selected by paddr[1:0].
- BASE_ADDR, 32'h10000000, register block base; decode on paddr[ADDR_WIDTH-1:4].
- TX_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd868, reset value of DIV (clocks per bit).

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- paddr  in  ADDR_WIDTH  byte address.
- pdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data, valid while ready=1, else 0.
- psel  in  1  select.
- penable  in  1  access phase.
- pwrite  in  1  1=write.
- pstb  in  4  byte strobes.
- ready  out  1  one-cycle completion pulse.
- perr  out  1  error, valid with ready.
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous.
- irq  out  1  level: (DR & ERBFI) | (THRE & ETBEI).

Behaviour:
- Reset values: ready=0, perr=0, prdata=0, txd=1, irq=0, FIFO empty, RBR=0, DR/OE/FE=0, IER=0, DIV=DEFAULT_DIV, both FSMs IDLE.
- Bus handshake:
  - Access completes in the cycle after psel&penable&!ready; ready is high for exactly one cycle, then low.
  - The side effect occurs on the same edge that raises ready.
  - Back-to-back accesses therefore take 2 cycles minimum.
- Register map (offset from BASE_ADDR; data on lane paddr[1:0]):
  - +0 W THR: push pdata lane byte if the lane's pstb bit is set. FIFO full: drop byte, perr=1.
  - +0 R RBR: return byte; clear DR.
  - +1 RW IER: bit0 ERBFI, bit1 ETBEI.
  - +5 R LSR: bit0 DR, bit1 OE, bit3 FE, bit5 THRE (FIFO empty), bit6 TEMT (FIFO empty and TX FSM IDLE). Read clears OE and FE.
  - +8 RW DIV: 16 bits, lanes 0–1 honour pstb. A write of 0 is stored as 1.
  - Any other address in the block: read 0, write ignored, perr=0.
  - Writes to LSR: ignored, perr=1.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts exactly DIV clocks.
  - Pop FIFO on IDLE->START.
  - Return directly STOP->START when FIFO non-empty (no idle gap).
  - A DIV change takes effect at the next bit boundary.
- RX path:
  - Synchronise rxd with a 2-flop synchroniser.
  - IDLE waits for high->low.
  - START samples at DIV/2 (integer floor). If the sample is high, treat as a glitch and return to IDLE.
  - DATA samples 8 bits every DIV clocks.
  - STOP samples once. If low, set FE; the byte is still delivered.
  - Delivery: if DR=0, load RBR and set DR. If DR=1, discard the new byte and set OE.
- Simultaneous events:
  - RBR read and delivery on the same edge: new byte loaded, DR stays 1, no OE.
  - LSR read and error on the same edge: the error wins (bit stays set).
  - THR write into a full FIFO with a pop on the same edge: accepted, no perr.
- FIFO uses pointers one bit wider than log2(TX_DEPTH) for full/empty; wrap-around must be seamless.
- Reset asserted mid-frame: txd returns to 1 asynchronously, FIFO contents are lost, and no partial byte is delivered to RBR.

Test Plan:
- Reset then DIV=4; write 0x55 to +0 -> txd low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, high 4 clocks; LSR reads 0x60 before and after.
- Write TX_DEPTH+1 bytes back-to-back with DIV=1000 -> first TX_DEPTH+1 accepted (one popped immediately); next write gives perr=1 with ready; frames back-to-back with no idle.
- Drive rxd frame 0xA3 at DIV=8 -> LSR bit0=1; RBR read returns 0xA3 and clears DR; irq follows DR when ERBFI=1.
- Two frames without reading RBR -> RBR holds first byte, LSR=0x63 on first read, 0x60 on second (OE cleared).
- Frame with low stop bit -> FE set, byte delivered; 1-clock low glitch at DIV=8 -> nothing received.
- Assert presetn low mid-TX-frame -> txd=1 immediately, LSR=0x60 after release, DIV=DEFAULT_DIV.
